// File: rtl/eviction_write_buffer.sv
// eviction_write_buffer
//   Line-granular write buffer between the L2 cache and physical memory.
//   Dirty-line evictions from L2 are absorbed into a small circular FIFO so a
//   following L2 miss read can go to memory first.  Buffered lines drain to
//   memory in the background whenever L2 is quiet (or when a write finds the
//   buffer full).  L2 reads that hit a buffered line are served from the buffer.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   l2_read / l2_write        L2 request (held until l2_resp), never both
//   l2_addr, l2_wdata         line address ([4:0] ignored) and writeback data
//   l2_rdata, l2_resp         read data and one-cycle completion pulse
//   mem_read / mem_write      memory request (held until mem_resp)
//   mem_addr, mem_wdata       memory line address and write data
//   mem_wmask                 all ones during mem_write, else zero
//   mem_resp, mem_rdata       memory completion and read data
//   empty                     no valid entries buffered
module eviction_write_buffer #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_read,
    input  logic                l2_write,
    input  logic [31:0]         l2_addr,
    input  logic [LINE_W-1:0]   l2_wdata,
    output logic [LINE_W-1:0]   l2_rdata,
    output logic                l2_resp,
    output logic                mem_read,
    output logic                mem_write,
    output logic [31:0]         mem_addr,
    output logic [LINE_W-1:0]   mem_wdata,
    output logic [LINE_W/8-1:0] mem_wmask,
    input  logic                mem_resp,
    input  logic [LINE_W-1:0]   mem_rdata,
    output logic                empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TAG_W = 27;

    typedef enum logic [1:0] {IDLE, RESP, MEM_RD, DRAIN} state_t;

    state_t              state;
    state_t              state_nx;
    logic [DEPTH-1:0]    valid;
    logic [TAG_W-1:0]    tag  [DEPTH];
    logic [LINE_W-1:0]   line [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    // A read hit taken during a drain: l2_resp goes out next cycle.
    logic                resp_pend;

    logic                hit;
    logic [PTR_W-1:0]    hit_idx;
    logic                full;
    logic                idle_eval;
    logic                do_coalesce;
    logic                do_enq;
    logic                do_rd_hit;
    logic                do_drain_hit;
    logic                do_deq;
    logic                do_mem_fill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    // Coalescing keeps at most one valid entry per tag, so at most one hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tag[i] == l2_addr[31:5]) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    // Entries are appended at tail and retired at head in order, so the slot
    // at tail is occupied only when every slot is.
    assign full  = valid[tail];
    assign empty = ~|valid;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // While a drain-hit response is going out, the L2 request is still held;
    // it must not be taken as a fresh request in that IDLE cycle.
    assign idle_eval = (state == IDLE) && !resp_pend;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (idle_eval) begin
                    if (l2_write)
                        state_nx = (hit || !full) ? RESP : DRAIN;
                    else if (l2_read)
                        state_nx = hit ? RESP : MEM_RD;
                    else if (!empty)
                        state_nx = DRAIN;
                end
            end
            RESP:    state_nx = IDLE;
            MEM_RD:  if (mem_resp) state_nx = RESP;
            DRAIN:   if (mem_resp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        do_coalesce  = idle_eval && l2_write && hit;
        do_enq       = idle_eval && l2_write && !hit && !full;
        do_rd_hit    = idle_eval && !l2_write && l2_read && hit;
        do_drain_hit = (state == DRAIN) && l2_read && hit && !resp_pend;
        do_deq       = (state == DRAIN) && mem_resp;
        do_mem_fill  = (state == MEM_RD) && mem_resp;

        l2_resp   = (state == RESP) || resp_pend;
        mem_read  = (state == MEM_RD);
        mem_write = (state == DRAIN);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (state == MEM_RD)
            mem_addr = l2_addr;
        if (state == DRAIN) begin
            mem_addr  = {tag[head], 5'b0};
            mem_wdata = line[head];
            mem_wmask = '1;
        end
    end

    // Line storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (do_coalesce)
            line[hit_idx] <= l2_wdata;
        if (do_enq) begin
            tag[tail]  <= l2_addr[31:5];
            line[tail] <= l2_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            head      <= '0;
            tail      <= '0;
            resp_pend <= 1'b0;
            l2_rdata  <= '0;
        end else begin
            resp_pend <= do_drain_hit;
            if (do_enq) begin
                valid[tail] <= 1'b1;
                tail        <= ptr_inc(tail);
            end
            if (do_deq) begin
                valid[head] <= 1'b0;
                head        <= ptr_inc(head);
            end
            if (do_rd_hit || do_drain_hit)
                l2_rdata <= line[hit_idx];
            else if (do_mem_fill)
                l2_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_eviction_write_buffer.sv
module tb_eviction_write_buffer;

    localparam int DEPTH  = 2;
    localparam int LINE_W = 256;
    localparam int MW     = LINE_W / 8;

    logic              clk;
    logic              rst;
    logic              l2_read;
    logic              l2_write;
    logic [31:0]       l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [MW-1:0]     mem_wmask;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;
    logic              empty;

    eviction_write_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: ordered list of buffered lines plus a sparse memory.
    logic [26:0]       q_addr[$];
    logic [255:0]      q_data[$];
    logic [255:0]      mem_model[logic [26:0]];
    logic [26:0]       wr_order[$];
    logic [255:0]      last_wr_data;
    int                last_wr_resp_cyc = -1;
    int                last_rd_resp_cyc = -1;
    int                rd_start_cyc     = -1;
    int                rd_start_wr      = -1;
    int                n_rd_cyc = 0;
    int                n_wr_cyc = 0;
    bit                prev_resp = 1'b0;
    bit                prev_mrd  = 1'b0;

    int                mem_lat = -1;
    int                resp_c_g;
    logic [255:0]      resp_data;
    bit                resp_busy;
    bit                resp_empty;

    task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit c);
        checks++;
        if (!c) begin
            failures++;
            $display("FAIL %s actual=0 required=1", name);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [26:0] t);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = ({5'b0, t} * (32'(i) + 32'd3)) ^ 32'h5A5A_1234;
        return r;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] mem_value(input logic [26:0] t);
        if (mem_model.exists(t))
            return mem_model[t];
        return init_line(t);
    endfunction

    function automatic int q_find(input logic [26:0] t);
        for (int i = 0; i < q_addr.size(); i++)
            if (q_addr[i] == t)
                return i;
        return -1;
    endfunction

    // Memory responder: answers each request after mem_lat cycles (random when negative).
    initial begin
        int rcnt;
        int cur_lat;
        rcnt = 0;
        cur_lat = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_resp) begin
                mem_resp = 1'b0;
                rcnt = 0;
            end else if (rst) begin
                rcnt = 0;
            end else if (mem_read || mem_write) begin
                if (rcnt == 0)
                    cur_lat = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
                if (rcnt >= cur_lat) begin
                    mem_resp = 1'b1;
                    if (mem_read)
                        mem_rdata = mem_value(mem_addr[31:5]);
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            q_addr.delete();
            q_data.delete();
            prev_resp = 1'b0;
            prev_mrd  = 1'b0;
        end else if (chk_en) begin
            int idx;
            check_true("l2_legal", !(l2_read && l2_write));
            check_true("mem_excl", !(mem_read && mem_write));
            check_eq("wmask", mem_wmask, mem_write ? {MW{1'b1}} : '0);
            if (mem_read) begin
                n_rd_cyc++;
                if (!prev_mrd) begin
                    rd_start_cyc = cyc;
                    rd_start_wr  = n_wr_cyc;
                end
                check_eq("mem_read_addr", mem_addr[31:5], l2_addr[31:5]);
                check_true("mem_read_is_miss", l2_read && q_find(l2_addr[31:5]) < 0);
            end
            if (mem_write) begin
                n_wr_cyc++;
                check_true("drain_nonempty", q_addr.size() > 0);
                if (q_addr.size() > 0) begin
                    check_eq("drain_addr", mem_addr[31:5], q_addr[0]);
                    check_eq("drain_data", mem_wdata, q_data[0]);
                end
            end
            if (l2_resp) begin
                check_true("resp_single", !prev_resp);
                if (l2_write) begin
                    idx = q_find(l2_addr[31:5]);
                    if (idx >= 0) begin
                        q_data[idx] = l2_wdata;
                    end else begin
                        q_addr.push_back(l2_addr[31:5]);
                        q_data.push_back(l2_wdata);
                    end
                    check_true("occupancy", q_addr.size() <= DEPTH);
                end else if (l2_read) begin
                    idx = q_find(l2_addr[31:5]);
                    check_eq("read_data", l2_rdata,
                             (idx >= 0) ? q_data[idx] : mem_value(l2_addr[31:5]));
                end else begin
                    check_true("resp_without_req", 1'b0);
                end
            end
            check_eq("empty", empty, q_addr.size() == 0);
            if (mem_resp && mem_write && q_addr.size() > 0) begin
                mem_model[q_addr[0]] = q_data[0];
                wr_order.push_back(q_addr[0]);
                last_wr_data     = q_data[0];
                last_wr_resp_cyc = cyc;
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
            end
            if (mem_resp && mem_read)
                last_rd_resp_cyc = cyc;
            prev_resp = l2_resp;
            prev_mrd  = mem_read;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        l2_read  = 1'b0;
        l2_write = 1'b0;
        repeat (n) sync();
    endtask

    // Issue one L2 request at posedge+1; returns at posedge+1 after its l2_resp
    // with the request still asserted so the caller may chain another.
    task automatic l2_op(input bit is_wr, input logic [31:0] a, input logic [255:0] d,
                         output int req_c, output int resp_c);
        l2_read  = !is_wr;
        l2_write = is_wr;
        l2_addr  = a;
        l2_wdata = d;
        req_c    = cyc;
        resp_c   = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (l2_resp) begin
                resp_c     = cyc;
                resp_data  = l2_rdata;
                resp_busy  = mem_read || mem_write;
                resp_empty = empty;
                break;
            end
        end
        check_true("l2_resp_timeout", resp_c >= 0);
        sync();
    endtask

    // sel 0: mem_write seen, 1: mem_resp seen. Returns at the sampling negedge.
    task automatic wait_until(input int sel, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((sel == 0 && mem_write) || (sel == 1 && mem_resp)) begin
                ok = 1'b1;
                break;
            end
        end
        check_true(name, ok);
    endtask

    task automatic wait_empty();
        bit ok = 1'b0;
        l2_read  = 1'b0;
        l2_write = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (empty && !mem_write && !mem_read) begin
                ok = 1'b1;
                break;
            end
        end
        check_true("drain_timeout", ok);
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rq;
        int rs;
        int base;
        int nb;
        logic [255:0] d1;
        logic [255:0] d2;
        logic [255:0] d3;
        d1 = {8{32'h1111_0001}};
        d2 = {8{32'h2222_0002}};
        d3 = {8{32'h3333_0003}};

        rst = 1'b1;
        l2_read = 1'b0;
        l2_write = 1'b0;
        l2_addr = '0;
        l2_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_l2_resp", l2_resp, 0);
        check_eq("rst_mem_read", mem_read, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_wmask", mem_wmask, 0);
        check_eq("rst_l2_rdata", l2_rdata, 0);
        check_eq("rst_empty", empty, 1);
        sync();
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Single buffered write then its background drain.
        mem_lat = 3;
        l2_op(1'b1, 32'h1000, d1, rq, rs);
        check_eq("t1_latency", rs - rq, 1);
        check_eq("t1_no_mem_traffic", resp_busy, 0);
        check_eq("t1_empty_after_write", resp_empty, 0);
        idle(0);
        wait_until(0, "t1_drain_start");
        check_eq("t1_drain_addr", mem_addr, 32'h1000);
        check_eq("t1_drain_data", mem_wdata, d1);
        check_eq("t1_drain_mask", mem_wmask, 32'hFFFF_FFFF);
        wait_until(1, "t1_drain_resp");
        @(negedge clk);
        check_eq("t1_empty_after_drain", empty, 1);
        sync();
        wait_empty();

        // Coalescing: two writes to one line, one drain carrying the newer data.
        base = wr_order.size();
        l2_op(1'b1, 32'h1000, d1, rq, rs);
        l2_op(1'b1, 32'h1000, d2, rq, rs);
        check_eq("t2_coalesce_latency", rs - rq, 1);
        wait_empty();
        check_eq("t2_drain_count", wr_order.size() - base, 1);
        check_eq("t2_drain_data", last_wr_data, d2);

        // Full buffer: third write waits for the oldest line to drain.
        mem_lat = 4;
        base = wr_order.size();
        l2_op(1'b1, 32'h1000, d1, rq, rs);
        l2_op(1'b1, 32'h2000, d2, rq, rs);
        l2_op(1'b1, 32'h3000, d3, rq, rs);
        check_true("t3_drained_first", wr_order.size() > base);
        if (wr_order.size() > base) begin
            check_eq("t3_first_drain_addr", wr_order[base], 27'h80);
            check_eq("t3_resp_after_drain", rs, last_wr_resp_cyc + 2);
        end
        wait_empty();

        // Read hit from the buffer, no memory read.
        mem_lat = 6;
        l2_op(1'b1, 32'h2000, d3, rq, rs);
        nb = n_rd_cyc;
        l2_op(1'b0, 32'h2000, '0, rq, rs);
        check_eq("t4_hit_data", resp_data, d3);
        check_eq("t4_hit_latency", rs - rq, 1);
        check_eq("t4_no_mem_read", n_rd_cyc, nb);
        wait_empty();

        // Read miss bypasses the buffered write; memory answers after 5 cycles.
        mem_lat = 5;
        nb = n_wr_cyc;
        l2_op(1'b1, 32'h1000, d1, rq, rs);
        l2_op(1'b0, 32'h4000, '0, rq, rs);
        check_eq("t5_read_before_write", rd_start_wr, nb);
        check_eq("t5_mem_latency", last_rd_resp_cyc - rd_start_cyc, 5);
        check_eq("t5_resp_latency", rs - last_rd_resp_cyc, 1);
        check_eq("t5_read_data", resp_data, init_line(27'h200));
        wait_empty();

        // Reset in the middle of a drain.
        mem_lat = 100;
        l2_op(1'b1, 32'h1000, d1, rq, rs);
        idle(0);
        wait_until(0, "t6_drain_start");
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_mem_write", mem_write, 0);
        check_eq("t6_mem_read", mem_read, 0);
        check_eq("t6_empty", empty, 1);
        check_eq("t6_l2_resp", l2_resp, 0);
        sync();
        mem_lat = -1;
        idle(2);

        // Randomized traffic over a small set of lines.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = {16'h0, 4'(($urandom % 6) + 1), 12'h000} | 32'($urandom % 32);
            if ($urandom % 10 < 6)
                l2_op(1'b1, a, rand_line(), rq, rs);
            else
                l2_op(1'b0, a, '0, rq, rs);
            if ($urandom % 2 == 0)
                idle($urandom_range(1, 3));
        end
        wait_empty();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
